// File: rtl/time_set_ctrl.sv
// Set-time controller: debounced mode/inc buttons drive a RUN/SET_HR/SET_MIN/SET_SEC/LOAD FSM
// that edits a BCD shadow time and offers it to the clock counter over a valid/ready load port.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hr2,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_min2,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_sec2,
  input  logic [3:0] cur_sec1,
  output logic [3:0] set_hr2,
  output logic [3:0] set_hr1,
  output logic [3:0] set_min2,
  output logic [3:0] set_min1,
  output logic [3:0] set_sec2,
  output logic [3:0] set_sec1,
  output logic       load_valid,
  input  logic       load_ready,
  output logic       set_active,
  output logic [2:0] field_sel
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, LOAD} state_t;

  // Bit 0 is the mode button, bit 1 the inc button; active-low, so 1 means released.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      lvl_q, lvl_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];
  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_ev, mode_ev, inc_ev;

  state_t          state_q, state_d;
  logic            load_valid_q, load_valid_d;
  logic            set_active_q, set_active_d;
  logic [2:0]      field_sel_q, field_sel_d;
  logic [3:0]      dig_q [6];
  logic [3:0]      dig_d [6];

  function automatic logic [7:0] bcd_inc_hr(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u >= 4'd3)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_60(input logic [3:0] t, input logic [3:0] u);
    if (t > 4'd5 || u > 4'd9 || (t == 4'd5 && u == 4'd9)) return 8'h00;
    else if (u == 4'd9) return {t + 4'd1, 4'd0};
    else return {t, u + 4'd1};
  endfunction

  assign btn_raw = {btn_inc, btn_mode};

  // A counter only runs while the synchronised level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts it.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign rpt_ev  = ~lvl_q[1] & ~press_q[1] & (rpt_cnt_q == RP_LAST);
  assign mode_ev = press_q[0];
  assign inc_ev  = (press_q[1] | rpt_ev) & ~mode_ev;

  always_comb begin
    rpt_cnt_d = '0;
    if (~lvl_q[1] && !press_q[1] && !rpt_ev) rpt_cnt_d = rpt_cnt_q + RP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      lvl_q     <= 2'b11;
      press_q   <= 2'b00;
      rpt_cnt_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      rpt_cnt_q <= rpt_cnt_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      load_valid_q <= 1'b0;
      set_active_q <= 1'b0;
      field_sel_q  <= 3'b000;
    end else begin
      state_q      <= state_d;
      load_valid_q <= load_valid_d;
      set_active_q <= set_active_d;
      field_sel_q  <= field_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mode_ev) state_d = SET_HR;
      SET_HR:  if (mode_ev) state_d = SET_MIN;
      SET_MIN: if (mode_ev) state_d = SET_SEC;
      SET_SEC: if (mode_ev) state_d = LOAD;
      LOAD:    if (load_valid_q && load_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Flags are registered from the next state so they move on the same edge as the state.
  always_comb begin
    set_active_d = (state_d != RUN);
    load_valid_d = (state_d == LOAD);
    unique case (state_d)
      SET_HR:  field_sel_d = 3'b100;
      SET_MIN: field_sel_d = 3'b010;
      SET_SEC: field_sel_d = 3'b001;
      default: field_sel_d = 3'b000;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 6; i++) dig_d[i] = dig_q[i];
    unique case (state_q)
      RUN: if (mode_ev) begin
        dig_d[0] = cur_hr2;
        dig_d[1] = cur_hr1;
        dig_d[2] = cur_min2;
        dig_d[3] = cur_min1;
        dig_d[4] = cur_sec2;
        dig_d[5] = cur_sec1;
      end
      SET_HR:  if (inc_ev) {dig_d[0], dig_d[1]} = bcd_inc_hr(dig_q[0], dig_q[1]);
      SET_MIN: if (inc_ev) {dig_d[2], dig_d[3]} = bcd_inc_60(dig_q[2], dig_q[3]);
      SET_SEC: if (inc_ev) {dig_d[4], dig_d[5]} = bcd_inc_60(dig_q[4], dig_q[5]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 6; i++) dig_q[i] <= dig_d[i];
    end
  end

  assign set_hr2    = dig_q[0];
  assign set_hr1    = dig_q[1];
  assign set_min2   = dig_q[2];
  assign set_min1   = dig_q[3];
  assign set_sec2   = dig_q[4];
  assign set_sec1   = dig_q[5];
  assign load_valid = load_valid_q;
  assign set_active = set_active_q;
  assign field_sel  = field_sel_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: stimulus tasks push predicted output snapshots and load
// transfers; a monitor pops and compares whenever the DUT outputs change or a transfer happens.
module tb_time_set_ctrl;
  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst, btn_mode, btn_inc, load_ready;
  logic [3:0] cur_d [6];
  logic [3:0] set_hr2, set_hr1, set_min2, set_min1, set_sec2, set_sec1;
  logic       load_valid, set_active;
  logic [2:0] field_sel;

  typedef logic [28:0] snap_t;
  snap_t       exp_q[$];
  logic [23:0] load_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  // Reference model: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC, 4 LOAD; digits as plain integers.
  int    m_state;
  int    m_dig [6];
  snap_t m_prev;
  int    holds [3] = '{6, 12, 20};

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hr2(cur_d[0]), .cur_hr1(cur_d[1]), .cur_min2(cur_d[2]),
    .cur_min1(cur_d[3]), .cur_sec2(cur_d[4]), .cur_sec1(cur_d[5]),
    .set_hr2(set_hr2), .set_hr1(set_hr1), .set_min2(set_min2),
    .set_min1(set_min1), .set_sec2(set_sec2), .set_sec1(set_sec1),
    .load_valid(load_valid), .load_ready(load_ready),
    .set_active(set_active), .field_sel(field_sel)
  );

  function automatic snap_t dut_snap();
    return {set_hr2, set_hr1, set_min2, set_min1, set_sec2, set_sec1,
            load_valid, set_active, field_sel};
  endfunction

  function automatic logic [23:0] model_digits();
    return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3]), 4'(m_dig[4]), 4'(m_dig[5])};
  endfunction

  function automatic snap_t model_snap();
    logic [2:0] fs;
    case (m_state)
      1:       fs = 3'b100;
      2:       fs = 3'b010;
      3:       fs = 3'b001;
      default: fs = 3'b000;
    endcase
    return {model_digits(), (m_state == 4), (m_state != 0), fs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_push();
    snap_t s = model_snap();
    if (s != m_prev) begin
      exp_q.push_back(s);
      m_prev = s;
    end
  endtask

  // Two-digit field increment: any illegal or top value wraps to 00.
  task automatic m_field_inc(input int idx, input int modulo);
    int t = m_dig[idx];
    int u = m_dig[idx+1];
    int v = t * 10 + u;
    if (t > 9 || u > 9 || v >= modulo - 1) v = 0;
    else v = v + 1;
    m_dig[idx]   = v / 10;
    m_dig[idx+1] = v % 10;
  endtask

  task automatic m_mode();
    case (m_state)
      0: begin
        for (int k = 0; k < 6; k++) m_dig[k] = int'(cur_d[k]);
        m_state = 1;
      end
      1, 2, 3: m_state = m_state + 1;
      default: ;
    endcase
    m_push();
  endtask

  task automatic m_inc();
    if (m_state >= 1 && m_state <= 3) begin
      m_field_inc((m_state - 1) * 2, (m_state == 1) ? 24 : 60);
      m_push();
    end
  endtask

  task automatic drive(input bit m, input bit i, input int hold, input int gap);
    @(negedge clk);
    if (m) btn_mode = 1'b0;
    if (i) btn_inc = 1'b0;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // A clean press held for 'hold' clocks: one event, plus (hold-1)/R auto-repeats on inc.
  task automatic press(input bit m, input bit i, input int hold);
    if (m) m_mode();
    else if (i) m_inc();
    if (i) for (int k = 0; k < (hold - 1) / R; k++) m_inc();
    drive(m, i, hold, 10);
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    cur_d[0] = 4'(h / 10);  cur_d[1] = 4'(h % 10);
    cur_d[2] = 4'(mi / 10); cur_d[3] = 4'(mi % 10);
    cur_d[4] = 4'(s / 10);  cur_d[5] = 4'(s % 10);
  endtask

  task automatic noise_ready();
    @(posedge clk); #2 load_ready = 1'b1;
    @(posedge clk); #2 load_ready = 1'b0;
  endtask

  task automatic do_load(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    load_q.push_back(model_digits());
    m_state = 0;
    m_push();
    @(posedge clk); #2 load_ready = 1'b1;
    @(posedge clk); #2 load_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    m_state = 0;
    for (int k = 0; k < 6; k++) m_dig[k] = 0;
    m_push();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset_outputs", 32'(dut_snap()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_session();
    int h  = $urandom_range(0, 23);
    int mi = $urandom_range(0, 59);
    int s  = $urandom_range(0, 59);
    set_cur(h, mi, s);
    if ($urandom_range(0, 5) == 0) cur_d[$urandom_range(0, 5)] = 4'($urandom_range(10, 15));
    if ($urandom_range(0, 2) == 0) press(1'b0, 1'b1, 6);
    if ($urandom_range(0, 2) == 0) noise_ready();
    press(1'b1, 1'b0, 6);
    for (int f = 0; f < 3; f++) begin
      int n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) press(1'b0, 1'b1, holds[$urandom_range(0, 2)]);
      if ($urandom_range(0, 7) == 0) begin
        do_reset();
        return;
      end
      if ($urandom_range(0, 4) == 0) press(1'b1, 1'b1, 6);
      else press(1'b1, 1'b0, 6);
    end
    if ($urandom_range(0, 1) == 1) press(1'b0, 1'b1, 6);
    do_load($urandom_range(0, 6));
  endtask

  initial begin : monitor
    snap_t prev = '0;
    snap_t now;
    wait (mon_en);
    forever begin
      @(negedge clk);
      now = dut_snap();
      if (now !== prev) begin
        if (exp_q.size() == 0) check("unexpected_output_change", 32'(now), 32'(prev));
        else check("output_snapshot", 32'(now), 32'(exp_q.pop_front()));
        prev = now;
      end
      if (load_valid && load_ready) begin
        if (load_q.size() == 0)
          check("unexpected_load", 32'(dut_snap()), 32'(m_prev));
        else
          check("load_data", 32'({set_hr2, set_hr1, set_min2, set_min1, set_sec2, set_sec1}),
                32'(load_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b0; btn_mode = 1'b1; btn_inc = 1'b1; load_ready = 1'b0;
    set_cur(0, 0, 0);
    m_state = 0;
    for (int k = 0; k < 6; k++) m_dig[k] = 0;
    m_prev = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_snap()), 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Bouncing mode button: only the final stable low produces an event.
    set_cur(13, 47, 5);
    m_mode();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_mode = ((i / 2) % 2 == 1);
    end
    drive(1'b1, 1'b0, 6, 10);
    check("bounce_capture", 32'(dut_snap()), 32'({24'h134705, 1'b0, 1'b1, 3'b100}));
    press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
    do_load(2);

    // Hour wrap points.
    foreach (holds[j]) begin
      set_cur((j == 0) ? 23 : (j == 1) ? 9 : 19, 0, 0);
      press(1'b1, 1'b0, 6);
      press(1'b0, 1'b1, 6);
      press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
      do_load(1);
    end

    // Minute and second wrap without carry.
    set_cur(12, 59, 59);
    press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    press(1'b1, 1'b0, 6);
    check("min_sec_wrap", 32'({set_hr2, set_hr1, set_min2, set_min1, set_sec2, set_sec1}), 32'h120000);
    do_load(0);

    // Auto-repeat: held 4+8*3 clocks from 10 gives 14, release adds nothing.
    set_cur(8, 10, 30);
    press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 28);
    repeat (20) @(negedge clk);
    check("auto_repeat", 32'({set_min2, set_min1}), 32'h14);
    press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
    do_load(3);

    // Handshake: presses are dropped while LOAD waits for ready.
    set_cur(5, 5, 5);
    noise_ready();
    press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6); press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    press(1'b1, 1'b0, 6);
    check("load_hold", 32'({load_valid, set_active, field_sel}), 32'b11000);
    do_load(0);
    check("after_load", 32'({load_valid, set_active, field_sel}), 32'd0);

    // Mode beats inc in the same cycle; reset in SET_SEC discards the shadow time.
    set_cur(7, 30, 15);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 6);
    check("mode_priority", 32'({set_hr2, set_hr1, field_sel}), 32'({8'h07, 3'b010}));
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    do_reset();

    for (int n = 0; n < 15; n++) rand_session();

    repeat (20) @(negedge clk);
    check("snapshot_queue_drained", 32'(exp_q.size()), 32'd0);
    check("load_queue_drained", 32'(load_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
